// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the sync FIFO: width derivation and parameter legality.
package sync_fifo_pkg;

  // Ceiling log2 for elaboration-time width derivation (returns 0 for values <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Pointer width: addresses 0..DATA_DEPTH-1.
  function automatic int addr_w(input int depth);
    return clog2(depth);
  endfunction

  // Count width: one extra bit so the value DATA_DEPTH itself fits.
  function automatic int cnt_w(input int depth);
    return clog2(depth) + 1;
  endfunction

  // Legal configuration: at least two entries, thresholds inside the occupancy range.
  function automatic bit params_legal(input int depth, input int afull, input int aempty);
    return (depth >= 2) && (afull >= 1) && (afull <= depth) &&
           (aempty >= 0) && (aempty < depth);
  endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port storage: synchronous write port, combinational read port.
module fifo_sdp_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 128,
  parameter int AW         = 7
) (
  input  logic                  i_sys_clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DATA_DEPTH];

  // Store the write word; the array is intentionally left unreset.
  always_ff @(posedge i_sys_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy count, flags, error pulses,
// standard or first-word-fall-through read presentation.
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int DATA_DEPTH    = 128,
  parameter int FWFT_EN       = 0,
  parameter int AFULL_THRESH  = DATA_DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                         i_sys_clk,
  input  logic                         i_sys_rst_n,
  input  logic                         i_clr,
  input  logic                         i_wren,
  input  logic [DATA_WIDTH-1:0]        i_wdata,
  input  logic                         i_rden,
  output logic [DATA_WIDTH-1:0]        o_rdata,
  output logic                         o_rvalid,
  output logic                         o_full,
  output logic                         o_empty,
  output logic                         o_almost_full,
  output logic                         o_almost_empty,
  output logic [clog2(DATA_DEPTH):0]   o_data_count,
  output logic                         o_overflow,
  output logic                         o_underflow
);

  localparam int AW = addr_w(DATA_DEPTH);
  localparam int CW = cnt_w(DATA_DEPTH);

  localparam logic [AW-1:0] C_LAST_ADDR = AW'(DATA_DEPTH - 1);
  localparam logic [CW-1:0] C_DEPTH     = CW'(DATA_DEPTH);
  localparam logic [CW-1:0] C_AFULL     = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] C_AEMPTY    = CW'(AEMPTY_THRESH);

  generate
    if (!params_legal(DATA_DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_params
      $error("sync_fifo_ctrl: illegal DATA_DEPTH / threshold combination");
    end
  endgenerate

  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_ram_we;
  logic [DATA_WIDTH-1:0] w_ram_rdata;

  // Flags are pure decodes of the registered count, so they never glitch.
  assign o_full         = (r_count == C_DEPTH);
  assign o_empty        = (r_count == '0);
  assign o_almost_full  = (r_count >= C_AFULL);
  assign o_almost_empty = (r_count <= C_AEMPTY);
  assign o_data_count   = r_count;
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

  assign w_wr_acc = i_wren & ~o_full;
  assign w_rd_acc = i_rden & ~o_empty;
  // A clear cycle must not leave a stray word behind in the array.
  assign w_ram_we = w_wr_acc & ~i_clr;

  // Pointer, count and error-pulse bookkeeping; clear outranks any request.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (i_clr) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= i_wren & o_full;
      r_underflow <= i_rden & o_empty;
      // Explicit wrap so non-power-of-two depths index only valid entries.
      if (w_wr_acc) begin
        r_wr_ptr <= (r_wr_ptr == C_LAST_ADDR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= (r_rd_ptr == C_LAST_ADDR) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  fifo_sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DATA_DEPTH (DATA_DEPTH),
    .AW         (AW)
  ) u_ram (
    .i_sys_clk (i_sys_clk),
    .i_we      (w_ram_we),
    .i_waddr   (r_wr_ptr),
    .i_wdata   (i_wdata),
    .i_raddr   (r_rd_ptr),
    .o_rdata   (w_ram_rdata)
  );

  generate
    if (FWFT_EN == 0) begin : g_std
      logic [DATA_WIDTH-1:0] r_rdata;
      logic                  r_rvalid;

      // Registered read: data lands the cycle after the accepted pop and then holds.
      always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
          r_rdata  <= '0;
          r_rvalid <= 1'b0;
        end else if (i_clr) begin
          r_rvalid <= 1'b0;
        end else begin
          r_rvalid <= w_rd_acc;
          if (w_rd_acc) begin
            r_rdata <= w_ram_rdata;
          end
        end
      end

      assign o_rdata  = r_rdata;
      assign o_rvalid = r_rvalid;
    end else begin : g_fwft
      // Head word presented directly; forced to zero while empty so the
      // output shows a defined value out of reset instead of stale array data.
      assign o_rdata  = o_empty ? '0 : w_ram_rdata;
      assign o_rvalid = ~o_empty;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl: table-driven sequence on a depth-8 standard
// FIFO, a wrap-around stream on a depth-6 FIFO, and an FWFT instance.
module tb_sync_fifo_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Depth 8, standard mode, almost-full at 6, almost-empty at 2
  logic       a_clr = 0, a_wren = 0, a_rden = 0;
  logic [7:0] a_wdata = 0, a_rdata;
  logic       a_rvalid, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [3:0] a_count;

  // Depth 6, standard mode, default thresholds (afull 4, aempty 2)
  logic       b_clr = 0, b_wren = 0, b_rden = 0;
  logic [7:0] b_wdata = 0, b_rdata;
  logic       b_rvalid, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [3:0] b_count;

  // Depth 4, FWFT mode
  logic       f_clr = 0, f_wren = 0, f_rden = 0;
  logic [7:0] f_wdata = 0, f_rdata;
  logic       f_rvalid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [2:0] f_count;

  sync_fifo_ctrl #(.DATA_WIDTH(8), .DATA_DEPTH(8), .FWFT_EN(0),
                   .AFULL_THRESH(6), .AEMPTY_THRESH(2)) dut8 (
    .i_sys_clk(clk), .i_sys_rst_n(rst_n), .i_clr(a_clr), .i_wren(a_wren),
    .i_wdata(a_wdata), .i_rden(a_rden), .o_rdata(a_rdata), .o_rvalid(a_rvalid),
    .o_full(a_full), .o_empty(a_empty), .o_almost_full(a_af), .o_almost_empty(a_ae),
    .o_data_count(a_count), .o_overflow(a_ovf), .o_underflow(a_unf));

  sync_fifo_ctrl #(.DATA_WIDTH(8), .DATA_DEPTH(6), .FWFT_EN(0)) dut6 (
    .i_sys_clk(clk), .i_sys_rst_n(rst_n), .i_clr(b_clr), .i_wren(b_wren),
    .i_wdata(b_wdata), .i_rden(b_rden), .o_rdata(b_rdata), .o_rvalid(b_rvalid),
    .o_full(b_full), .o_empty(b_empty), .o_almost_full(b_af), .o_almost_empty(b_ae),
    .o_data_count(b_count), .o_overflow(b_ovf), .o_underflow(b_unf));

  sync_fifo_ctrl #(.DATA_WIDTH(8), .DATA_DEPTH(4), .FWFT_EN(1),
                   .AFULL_THRESH(3), .AEMPTY_THRESH(1)) dutf (
    .i_sys_clk(clk), .i_sys_rst_n(rst_n), .i_clr(f_clr), .i_wren(f_wren),
    .i_wdata(f_wdata), .i_rden(f_rden), .o_rdata(f_rdata), .o_rvalid(f_rvalid),
    .o_full(f_full), .o_empty(f_empty), .o_almost_full(f_af), .o_almost_empty(f_ae),
    .o_data_count(f_count), .o_overflow(f_ovf), .o_underflow(f_unf));

  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic       rd;
    logic       clr;
    int         cnt;
    logic       rv;
    logic [7:0] rdata;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic wr, input logic [7:0] wd, input logic rd, input logic clr,
                     input int cnt, input logic rv, input logic [7:0] rdata,
                     input logic ovf, input logic unf);
    vec_t v;
    v.wr = wr; v.wd = wd; v.rd = rd; v.clr = clr; v.cnt = cnt;
    v.rv = rv; v.rdata = rdata; v.ovf = ovf; v.unf = unf;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // Depth-8 outputs against an expected count and read state; flags from thresholds.
  task automatic chk8(input string tag, input int idx, input int cnt, input logic rv,
                      input logic [7:0] rdata, input logic ovf, input logic unf);
    chk({tag, "_count"}, idx, 32'(a_count), 32'(cnt));
    chk({tag, "_full"},  idx, 32'(a_full),  32'(cnt == 8));
    chk({tag, "_empty"}, idx, 32'(a_empty), 32'(cnt == 0));
    chk({tag, "_afull"}, idx, 32'(a_af),    32'(cnt >= 6));
    chk({tag, "_aempty"},idx, 32'(a_ae),    32'(cnt <= 2));
    chk({tag, "_rvalid"},idx, 32'(a_rvalid),32'(rv));
    chk({tag, "_rdata"}, idx, 32'(a_rdata), 32'(rdata));
    chk({tag, "_ovf"},   idx, 32'(a_ovf),   32'(ovf));
    chk({tag, "_unf"},   idx, 32'(a_unf),   32'(unf));
  endtask

  initial begin
    int q[$];
    int mcount, wi, cyc, exp_data;
    logic exp_wacc, exp_racc, exp_ovf, exp_unf;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    chk8("rst", 0, 0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst6_empty", 0, 32'(b_empty), 1);
    chk("rstf_rvalid", 0, 32'(f_rvalid), 0);
    rst_n = 1'b1;

    // ---------------- depth-8 directed table ----------------
    for (int i = 0; i < 8; i++) add(1, 8'(8'h10 + i), 0, 0, i + 1, 0, 8'h00, 0, 0);
    add(1, 8'h99, 0, 0, 8, 0, 8'h00, 1, 0);                // write while full
    add(1, 8'h98, 1, 0, 7, 1, 8'h10, 1, 0);                // full, both: read wins
    for (int i = 1; i < 8; i++) add(0, 8'h00, 1, 0, 7 - i, 1, 8'(8'h10 + i), 0, 0);
    add(0, 8'h00, 1, 0, 0, 0, 8'h17, 0, 1);                // read while empty
    add(0, 8'h00, 0, 0, 0, 0, 8'h17, 0, 0);                // pulse lasts one cycle
    add(1, 8'h21, 1, 0, 1, 0, 8'h17, 0, 1);                // empty, both: write wins
    add(1, 8'h22, 0, 0, 2, 0, 8'h17, 0, 0);
    add(1, 8'h23, 0, 0, 3, 0, 8'h17, 0, 0);
    for (int k = 0; k < 10; k++)                           // steady count under both
      add(1, 8'(8'h30 + k), 1, 0, 3, 1, (k < 3) ? 8'(8'h21 + k) : 8'(8'h30 + k - 3), 0, 0);
    add(1, 8'h3A, 0, 0, 4, 0, 8'h36, 0, 0);
    add(1, 8'h77, 1, 1, 0, 0, 8'h36, 0, 0);                // clear beats wren/rden
    add(0, 8'h00, 0, 0, 0, 0, 8'h36, 0, 0);
    add(1, 8'h55, 0, 0, 1, 0, 8'h36, 0, 0);                // lands at address 0
    add(0, 8'h00, 1, 0, 0, 1, 8'h55, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      a_wren = vecs[i].wr; a_wdata = vecs[i].wd; a_rden = vecs[i].rd; a_clr = vecs[i].clr;
      @(posedge clk); #1;
      chk8("tbl", i, vecs[i].cnt, vecs[i].rv, vecs[i].rdata, vecs[i].ovf, vecs[i].unf);
    end
    @(negedge clk);
    a_wren = 0; a_rden = 0; a_clr = 0;

    // ---------------- asynchronous reset mid-stream ----------------
    a_wren = 1; a_wdata = 8'h61;
    @(negedge clk); a_wdata = 8'h62;
    @(negedge clk); a_wren = 0; a_rden = 1;
    @(posedge clk); #1;
    chk8("pre_rst", 0, 1, 1'b1, 8'h61, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk8("async_rst", 0, 0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk); a_rden = 0; rst_n = 1'b1;
    @(negedge clk); a_wren = 1; a_wdata = 8'h66;
    @(negedge clk); a_wren = 0; a_rden = 1;
    @(posedge clk); #1;
    chk8("post_rst", 0, 0, 1'b1, 8'h66, 1'b0, 1'b0);
    @(negedge clk); a_rden = 0;

    // ---------------- depth-6 wrap-around stream ----------------
    mcount = 0; wi = 0; cyc = 0;
    while ((wi < 20 || mcount > 0) && cyc < 200) begin
      @(negedge clk);
      b_wren  = (wi < 20);
      b_wdata = 8'(8'hC0 + wi);
      b_rden  = (wi >= 20) || (cyc % 2 == 1);
      exp_wacc = b_wren && (mcount < 6);
      exp_racc = b_rden && (mcount > 0);
      exp_ovf  = b_wren && (mcount == 6);
      exp_unf  = b_rden && (mcount == 0);
      exp_data = 0;
      if (exp_racc) exp_data = q.pop_front();
      if (exp_wacc) begin q.push_back(int'(b_wdata)); wi++; end
      mcount = q.size();
      @(posedge clk); #1;
      chk("s6_count", cyc, 32'(b_count), 32'(mcount));
      chk("s6_le6", cyc, 32'(b_count <= 4'd6), 1);
      chk("s6_full", cyc, 32'(b_full), 32'(mcount == 6));
      chk("s6_afull", cyc, 32'(b_af), 32'(mcount >= 4));
      chk("s6_ovf", cyc, 32'(b_ovf), 32'(exp_ovf));
      chk("s6_unf", cyc, 32'(b_unf), 32'(exp_unf));
      chk("s6_rvalid", cyc, 32'(b_rvalid), 32'(exp_racc));
      if (exp_racc) chk("s6_rdata", cyc, 32'(b_rdata), 32'(exp_data));
      cyc++;
    end
    chk("s6_drained", cyc, 32'(cyc < 200), 1);
    chk("s6_empty_end", cyc, 32'(b_empty), 1);
    @(negedge clk); b_wren = 0; b_rden = 0;

    // ---------------- FWFT ----------------
    f_wren = 1; f_wdata = 8'hA5;
    @(posedge clk); #1;
    chk("fw_rdata", 0, 32'(f_rdata), 32'h A5);
    chk("fw_rvalid", 0, 32'(f_rvalid), 1);
    chk("fw_count", 0, 32'(f_count), 1);
    @(negedge clk); f_wren = 0;
    @(posedge clk); #1;
    chk("fw_hold", 1, 32'(f_rdata), 32'h A5);
    chk("fw_hold_rv", 1, 32'(f_rvalid), 1);
    @(negedge clk); f_wren = 1; f_wdata = 8'h5A;
    @(posedge clk); #1;
    chk("fw_head", 2, 32'(f_rdata), 32'h A5);
    chk("fw_count2", 2, 32'(f_count), 2);
    @(negedge clk); f_wren = 0; f_rden = 1;
    @(posedge clk); #1;
    chk("fw_next", 3, 32'(f_rdata), 32'h 5A);
    chk("fw_next_rv", 3, 32'(f_rvalid), 1);
    @(posedge clk); #1;
    chk("fw_empty", 4, 32'(f_empty), 1);
    chk("fw_empty_rv", 4, 32'(f_rvalid), 0);
    @(posedge clk); #1;
    chk("fw_unf", 5, 32'(f_unf), 1);
    @(negedge clk); f_rden = 0;
    @(posedge clk); #1;
    chk("fw_unf_clr", 6, 32'(f_unf), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Parametrised single-clock FIFO, successor to the basic sync FIFO. Adds:
- Selectable standard or first-word-fall-through (FWFT) read mode.
- Programmable almost-full and almost-empty flags.
- Occupancy count output.
- Overflow and underflow error pulses.
- Synchronous clear.
- Correct count on simultaneous read and write.
- Support for non-power-of-two depth.
It is the general-purpose buffer between same-clock producer/consumer stages.

Parameters:
DATA_WIDTH, 8, data word width in bits (>=1)
DATA_DEPTH, 128, number of entries (>=2, any integer)
FWFT_EN, 0, 0 = standard registered read, 1 = first-word-fall-through
AFULL_THRESH, DATA_DEPTH-2, o_almost_full asserts when count >= this value (1..DATA_DEPTH)
AEMPTY_THRESH, 2, o_almost_empty asserts when count <= this value (0..DATA_DEPTH-1)

Ports:
i_sys_clk  in  1  clock, all logic on rising edge
i_sys_rst_n  in  1  asynchronous active-low reset
i_clr  in  1  synchronous clear of FIFO state
i_wren  in  1  write request
i_wdata  in  DATA_WIDTH  write data
i_rden  in  1  read request (pop)
o_rdata  out  DATA_WIDTH  read data
o_rvalid  out  1  o_rdata valid qualifier
o_full  out  1  count == DATA_DEPTH
o_empty  out  1  count == 0
o_almost_full  out  1  count >= AFULL_THRESH
o_almost_empty  out  1  count <= AEMPTY_THRESH
o_data_count  out  AW+1  occupancy 0..DATA_DEPTH, where AW = clog2(DATA_DEPTH)
o_overflow  out  1  one-cycle pulse: write was rejected
o_underflow  out  1  one-cycle pulse: read was rejected

Behaviour:
- Reset is asynchronous, active-low, and i_sys_rst_n is the reset of i_sys_clk. Reset values:
  - Pointers and count = 0.
  - o_rdata = 0, o_rvalid = 0, o_overflow = 0, o_underflow = 0.
  - o_empty = 1, o_almost_empty = 1, o_full = 0.
  - o_almost_full = 0, unless AFULL_THRESH == 0 (illegal).
  - Memory array is not reset.
- Acceptance terms:
  - wr_acc = i_wren & !o_full.
  - rd_acc = i_rden & !o_empty.
  - Flags are evaluated from the registered count of the current cycle.
- Pointers:
  - wr_ptr and rd_ptr are AW bits wide.
  - Each increments on its accept and wraps from DATA_DEPTH-1 to 0 (explicit compare, not natural overflow).
- Count update:
  - +1 on wr_acc & !rd_acc.
  - -1 on rd_acc & !wr_acc.
  - Unchanged when both or neither are accepted.
  - Both pointers still advance when both are accepted.
- Full with wren & rden asserted: read accepted, write rejected (o_overflow pulses); count becomes DATA_DEPTH-1.
- Empty with wren & rden asserted: write accepted, read rejected (o_underflow pulses); count becomes 1. There is no read-through bypass in either mode.
- Standard mode (FWFT_EN=0):
  - On rd_acc, o_rdata <= mem[rd_ptr] at the same edge, i.e. valid in the cycle after the request.
  - o_rvalid is a registered one-cycle pulse aligned with the new o_rdata.
  - o_rdata holds its value otherwise.
- FWFT mode (FWFT_EN=1):
  - o_rdata = mem[rd_ptr] combinationally.
  - o_rvalid = !o_empty.
  - A word written into an empty FIFO appears on o_rdata the cycle after the write edge.
  - rd_acc consumes the presented word.
- Flags: o_full, o_empty, o_almost_full and o_almost_empty are pure decodes of the count register. They are glitch-free and valid the cycle after the accepting edge.
- Error pulses:
  - o_overflow is registered, high for exactly one cycle after any edge where i_wren & o_full.
  - o_underflow is likewise registered, for i_rden & o_empty.
  - Rejected operations change no state.
- i_clr:
  - Synchronous and has priority over i_wren/i_rden in the same cycle.
  - Zeroes pointers, count, o_rvalid and the error pulses.
  - Memory contents and the registered o_rdata are untouched.
  - No error pulses are generated for requests in a clear cycle.
- Reset asserted mid-operation clears everything immediately. The first write after release lands at address 0.

Decomposition:
- Shared package/header sync_fifo_pkg holds:
  - clog2 constant function.
  - AW/CW width derivations.
  - Parameter legality checks: DATA_DEPTH >= 2; AFULL_THRESH in 1..DATA_DEPTH; AEMPTY_THRESH < DATA_DEPTH.
- One sub-module, fifo_sdp_ram:
  - Simple dual-port RAM of DATA_DEPTH x DATA_WIDTH.
  - Synchronous write, plus a combinational read port.
  - The top level registers the read for standard mode.
- Pointer/count/flag control lives in the top module.

Test Plan:
- Reset release, DEPTH=8, FWFT=0: write 8 words 0x10..0x17 -> o_full=1 and count=8 after the 8th edge; o_almost_full=1 from count=6.
- Read 8 words -> o_rdata 0x10..0x17, each one cycle after rden, with o_rvalid pulses; o_empty=1 at end; then rden once -> o_underflow pulses for one cycle, rd_ptr unchanged.
- Wrap-around, DEPTH=6 (non-power-of-two): stream 20 words with interleaved reads -> data order preserved, pointers wrap 5->0, o_data_count never exceeds 6.
- Simultaneous, count=3: 10 cycles of wren & rden -> count stays 3, data in order. At full, wren & rden -> count=5 of 6 and o_overflow pulses. At empty, both -> count=1 and o_underflow pulses.
- FWFT=1: write 0xA5 into an empty FIFO -> o_rdata=0xA5 and o_rvalid=1 the next cycle without rden; rden pops -> o_empty=1.
- i_clr with count=4 and wren asserted -> next cycle count=0, o_empty=1, no write stored. Async reset pulse mid-stream -> all outputs at reset values immediately.
